imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//   Boot-time writer for the instruction memory read by fetch_instr. Accepts a byte stream
//   (valid/ready), parses a 2-byte word-count header, packs little-endian bytes into 32-bit
//   instructions, writes them to consecutive word addresses, checks a trailing XOR checksum.
//   Holds the RV32I core in reset (core_hold) while a load is in progress or has failed.
// PARAMETERS
//   NUM_INSTR       1024                 instruction memory depth in words (matches fetch_instr)
//   ADDR_W          $clog2(NUM_INSTR)    word-address width
//   TIMEOUT_CYCLES  65536                max idle cycles between accepted bytes; 0 disables timeout
// PORTS
//   clk         in   1       system clock, all logic on posedge
//   rst         in   1       synchronous, active-high reset
//   start       in   1       1-cycle pulse: begin a load; ignored unless state is IDLE, DONE or ERR
//   byte_in     in   8       stream byte
//   byte_valid  in   1       byte_in valid
//   byte_ready  out  1       loader can accept; transfer when byte_valid && byte_ready
//   wr_en       out  1       1-cycle instruction-memory write strobe
//   wr_addr     out  ADDR_W  word address (core PC[ADDR_W+1:2])
//   wr_data     out  32      instruction word
//   core_hold   out  1       1 = core must be held in reset
//   done        out  1       load completed, checksum matched (sticky until start/rst)
//   error       out  1       load failed (sticky until start/rst)
//   word_count  out  16      header count of the current/last load
// BEHAVIOUR
//   Reset: state IDLE; byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, core_hold=0, done=0,
//     error=0, word_count=0; byte lane, checksum, timeout counter cleared. Reset wins over all.
//   States: IDLE, HDR_LO, HDR_HI, DATA, CHECK, DONE, ERR.
//   start in IDLE/DONE/ERR -> HDR_LO; clears done, error, wr_addr, checksum, byte lane.
//   HDR_LO: accepted byte -> word_count[7:0]; -> HDR_HI.
//   HDR_HI: accepted byte -> word_count[15:8]. Full count N > NUM_INSTR -> ERR;
//     N == 0 -> CHECK; else -> DATA.
//   DATA: byte k of word lands in wr_data[8k+7:8k] (k=0..3, little-endian); checksum ^= byte.
//     On 4th byte handshake wr_en=1 in the NEXT cycle with completed word at wr_addr;
//     wr_addr increments the cycle after wr_en. After word N written -> CHECK.
//     Word assembled in a separate buffer: a byte accepted during the wr_en cycle is legal.
//   CHECK: accepted byte == checksum (XOR of payload bytes only) -> DONE, else -> ERR.
//   byte_ready=1 exactly in HDR_LO, HDR_HI, DATA, CHECK (no back-pressure within a load).
//   core_hold=1 in HDR_LO..CHECK and ERR; 0 in IDLE and DONE. done=1 only in DONE; error=1 only in ERR.
//   Timeout: counter clears on each accepted byte and on entry to HDR_LO; if it reaches
//     TIMEOUT_CYCLES while in HDR_LO..CHECK -> ERR. Partial word at timeout is never written.
//   wr_en never asserted outside DATA-following cycle; never more than N writes per load.
//   wr_addr does not wrap: N <= NUM_INSTR guarantees last address NUM_INSTR-1.
//   start while HDR_LO..CHECK: ignored. rst mid-load: aborts, IDLE next cycle, memory contents kept.
// STRUCTURE
//   loader_pkg: state enum loader_state_t, HDR_BYTES=2, BYTES_PER_WORD=4.
//   Sub-module byte_packer: byte lane counter + 32-bit shift/assemble buffer, word_valid pulse;
//     top holds FSM, address counter, checksum, timeout counter.
// TESTING
//   1 start; bytes 02 00 | 13 05 a0 00 | 93 05 b0 00 | 90 -> wr 0:0x00a00513, 1:0x00b00593;
//     done=1, core_hold 1->0, word_count=2.
//   2 same stream, checksum 91 -> error=1, done=0, core_hold stays 1, exactly 2 writes.
//   3 header 01 04 (N=1025, NUM_INSTR=1024) -> ERR on cycle after header, zero writes.
//   4 TIMEOUT_CYCLES=16; random valid gaps <16 load OK; 20-cycle stall after 2nd data byte
//     -> ERR, no write of partial word.
//   5 rst high mid-DATA -> all outputs at reset values next cycle; fresh start + case 1 stream
//     -> writes begin at addr 0.
//   6 header 00 00, checksum 00 -> DONE, zero writes; start pulsed during DATA ignored.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   loader_state_t  : load FSM states
//   HDR_BYTES       : bytes in the little-endian word-count header
//   BYTES_PER_WORD  : stream bytes packed into one instruction word
//   is_loading()    : true while a load is in flight (HDR_LO..CHECK)
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR_LO,
    HDR_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  function automatic logic is_loading(input loader_state_t s);
    return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CHECK);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into 32-bit words.
//   clk, rst    : system clock, synchronous active-high reset
//   clear       : restart at lane 0 (new load)
//   load        : byte_in is a payload byte to pack this cycle
//   byte_in     : payload byte
//   last_lane   : the next loaded byte completes a word
//   word        : most recently completed word (held until the next one)
//   word_valid  : 1-cycle pulse, the cycle after the completing byte
// The completed word is copied out of the assembly buffer, so a byte arriving
// while word_valid is high starts the next word without disturbing 'word'.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic        last_lane,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam int LANE_W = $clog2(BYTES_PER_WORD);
  localparam logic [LANE_W-1:0] LAST = LANE_W'(BYTES_PER_WORD - 1);

  logic [LANE_W-1:0] lane;
  logic [31:0]       buffer;

  assign last_lane = (lane == LAST);

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane       <= '0;
      buffer     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane   <= '0;
        buffer <= '0;
      end else if (load) begin
        if (last_lane) begin
          word       <= {byte_in, buffer[23:0]};
          word_valid <= 1'b1;
          lane       <= '0;
        end else begin
          buffer[8*lane +: 8] <= byte_in;
          lane                <= lane + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader. Stream format:
//   count_lo, count_hi, N*4 payload bytes (little-endian words), xor checksum.
// Ports:
//   clk, rst            : system clock, synchronous active-high reset
//   start               : begin a load (honoured in IDLE, DONE, ERR)
//   byte_in/byte_valid  : input stream; byte_ready accepts it
//   wr_en/wr_addr/wr_data : instruction-memory write port
//   core_hold           : keep the core in reset (loading or failed)
//   done / error        : sticky load outcome
//   word_count          : header count of the current/last load
module imem_loader
  import loader_pkg::*;
#(
  parameter int NUM_INSTR      = 1024,
  parameter int ADDR_W         = $clog2(NUM_INSTR),
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  loader_state_t state, next_state;

  logic                   accept;
  logic                   start_load;
  logic                   last_lane;
  logic                   timed_out;
  logic [8*HDR_BYTES-1:0] hdr_n;
  logic [15:0]            word_idx;
  logic [7:0]             checksum;
  logic [31:0]            tmo_cnt;

  assign byte_ready = is_loading(state);
  assign core_hold  = is_loading(state) || (state == ERR);
  assign done       = (state == DONE);
  assign error      = (state == ERR);

  assign accept     = byte_valid && byte_ready;
  assign start_load = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  // Full count as it stands once the high header byte is accepted.
  assign hdr_n      = {byte_in, word_count[7:0]};
  assign timed_out  = (TIMEOUT_CYCLES != 0) && is_loading(state) &&
                      (tmo_cnt >= 32'(TIMEOUT_CYCLES));

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_load),
    .load       (accept && (state == DATA)),
    .byte_in    (byte_in),
    .last_lane  (last_lane),
    .word       (wr_data),
    .word_valid (wr_en)
  );

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERR: if (start_load) next_state = HDR_LO;
      HDR_LO:          if (accept) next_state = HDR_HI;
      HDR_HI: begin
        if (accept) begin
          if (int'(hdr_n) > NUM_INSTR) next_state = ERR;
          else if (hdr_n == '0)        next_state = CHECK;
          else                         next_state = DATA;
        end
      end
      DATA: begin
        // The write of the last word lands in the first CHECK cycle.
        if (accept && last_lane && (word_idx == word_count - 16'd1))
          next_state = CHECK;
      end
      CHECK:   if (accept) next_state = (byte_in == checksum) ? DONE : ERR;
      default: next_state = IDLE;
    endcase
    if (timed_out) next_state = ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_addr    <= '0;
      word_count <= '0;
      word_idx   <= '0;
      checksum   <= '0;
      tmo_cnt    <= '0;
    end else begin
      state <= next_state;
      if (start_load) begin
        wr_addr  <= '0;
        word_idx <= '0;
        checksum <= '0;
        tmo_cnt  <= '0;
      end else begin
        // Hold at the top address instead of wrapping after the final write.
        if (wr_en && (wr_addr != ADDR_W'(NUM_INSTR - 1)))
          wr_addr <= wr_addr + 1'b1;

        if (accept) begin
          case (state)
            HDR_LO: word_count[7:0]  <= byte_in;
            HDR_HI: word_count[15:8] <= byte_in;
            DATA: begin
              checksum <= checksum ^ byte_in;
              if (last_lane) word_idx <= word_idx + 16'd1;
            end
            default: ;
          endcase
        end

        if (!is_loading(state) || accept) tmo_cnt <= '0;
        else if (tmo_cnt != '1)           tmo_cnt <= tmo_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int NUM_INSTR = 1024;
  localparam int ADDR_W    = 10;
  localparam int TMO       = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        byte_in = '0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              core_hold;
  logic              done;
  logic              error;
  logic [15:0]       word_count;

  imem_loader #(
    .NUM_INSTR      (NUM_INSTR),
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_hold  (core_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  logic [7:0]        good[$];
  logic [7:0]        bad[$];

  always @(negedge clk) begin
    if (wr_en) begin
      wa.push_back(wr_addr);
      wd.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input int i);
    return (i == 0) ? 32'h00a00513 : 32'h00b00593;
  endfunction

  // Called at a negedge; returns at the negedge after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    repeat (gap) @(negedge clk);
    while (!byte_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!byte_ready) check("byte_ready_wait", {31'd0, byte_ready}, 32'd1);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_range(input logic [7:0] s[$], input int lo, input int hi, input int max_gap);
    for (int i = lo; i <= hi; i++)
      send_byte(s[i], (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n_exp);
    @(negedge clk);
    check({tag, "_nwr"}, wa.size(), n_exp);
    for (int i = 0; i < n_exp; i++) begin
      if (i < wa.size()) begin
        check({tag, "_addr"}, {22'd0, wa[i]}, i);
        check({tag, "_data"}, wd[i], exp_word(i));
      end
    end
    wa.delete();
    wd.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    good = '{8'h02, 8'h00, 8'h13, 8'h05, 8'ha0, 8'h00,
             8'h93, 8'h05, 8'hb0, 8'h00, 8'h90};
    bad  = good;
    bad[10] = 8'h91;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, byte_ready}, 0);
    check("rst_wr_en", {31'd0, wr_en}, 0);
    check("rst_hold",  {31'd0, core_hold}, 0);
    check("rst_done",  {31'd0, done}, 0);
    check("rst_error", {31'd0, error}, 0);
    check("rst_count", {16'd0, word_count}, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: good load
    pulse_start();
    check("c1_hold_load", {31'd0, core_hold}, 1);
    send_range(good, 0, 1, 0);
    check("c1_count_hdr", {16'd0, word_count}, 2);
    send_range(good, 2, 5, 0);
    check("c1_wr_en", {31'd0, wr_en}, 1);
    check("c1_wr_addr0", {22'd0, wr_addr}, 0);
    check("c1_wr_data0", wr_data, 32'h00a00513);
    send_range(good, 6, 6, 0);
    check("c1_wr_en_pulse", {31'd0, wr_en}, 0);
    check("c1_addr_inc", {22'd0, wr_addr}, 1);
    send_range(good, 7, 10, 0);
    check("c1_done", {31'd0, done}, 1);
    check("c1_error", {31'd0, error}, 0);
    check("c1_hold_end", {31'd0, core_hold}, 0);
    check("c1_count", {16'd0, word_count}, 2);
    check_writes("c1", 2);

    // 2: bad checksum
    pulse_start();
    check("c2_done_cleared", {31'd0, done}, 0);
    send_range(bad, 0, 10, 0);
    check("c2_error", {31'd0, error}, 1);
    check("c2_done", {31'd0, done}, 0);
    check("c2_hold", {31'd0, core_hold}, 1);
    check_writes("c2", 2);

    // 3: oversize header
    pulse_start();
    check("c3_error_cleared", {31'd0, error}, 0);
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    check("c3_error", {31'd0, error}, 1);
    check("c3_ready", {31'd0, byte_ready}, 0);
    check("c3_count", {16'd0, word_count}, 32'h0401);
    check_writes("c3", 0);

    // 4: timeout
    pulse_start();
    send_range(good, 0, 10, TMO - 1);
    check("c4_gap_done", {31'd0, done}, 1);
    check_writes("c4a", 2);
    pulse_start();
    send_range(good, 0, 3, 0);
    repeat (20) @(negedge clk);
    check("c4_tmo_error", {31'd0, error}, 1);
    check("c4_tmo_hold", {31'd0, core_hold}, 1);
    check_writes("c4b", 0);

    // 5: reset mid-DATA
    pulse_start();
    send_range(good, 0, 7, 0);
    check("c5_pre_addr", {22'd0, wr_addr}, 1);
    rst = 1'b1;
    @(negedge clk);
    check("c5_ready", {31'd0, byte_ready}, 0);
    check("c5_wr_en", {31'd0, wr_en}, 0);
    check("c5_wr_addr", {22'd0, wr_addr}, 0);
    check("c5_wr_data", wr_data, 0);
    check("c5_hold", {31'd0, core_hold}, 0);
    check("c5_done", {31'd0, done}, 0);
    check("c5_error", {31'd0, error}, 0);
    check("c5_count", {16'd0, word_count}, 0);
    rst = 1'b0;
    @(negedge clk);
    wa.delete();
    wd.delete();
    pulse_start();
    send_range(good, 0, 10, 0);
    check("c5_done_after", {31'd0, done}, 1);
    check_writes("c5", 2);

    // 6: empty load, then start ignored mid-DATA
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("c6_check_ready", {31'd0, byte_ready}, 1);
    send_byte(8'h00, 0);
    check("c6_done", {31'd0, done}, 1);
    check("c6_hold", {31'd0, core_hold}, 0);
    check("c6_count", {16'd0, word_count}, 0);
    check_writes("c6a", 0);
    pulse_start();
    send_range(good, 0, 3, 0);
    pulse_start();
    check("c6_still_loading", {31'd0, byte_ready}, 1);
    send_range(good, 4, 10, 0);
    check("c6_done2", {31'd0, done}, 1);
    check("c6_count2", {16'd0, word_count}, 2);
    check_writes("c6b", 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
